// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one combinational ALU between NREQ requesters
//
// Purpose: accepts ALU ops from NREQ requesters over valid/ready, grants one at a
// time in round-robin order, presents registered operands to an external ALU,
// captures its result/flags one cycle later and returns them tagged with the
// requester index.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       per-requester handshake (req_ready one-hot or zero)
//   req_a/req_b/req_op        packed per-requester operands and op code
//   alu_a/alu_b/alu_op        registered operands driven to the ALU
//   alu_result/zero/carry     ALU outputs, sampled at the end of EXEC
//   rsp_valid/rsp_ready       response handshake
//   rsp_id/result/zero/carry  captured response, held stable while stalled
//   busy                      high whenever the arbiter is not idle

module alu_arbiter #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4,
    parameter int IDW   = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ*3-1:0]   req_op,
    output logic [WIDTH-1:0]    alu_a,
    output logic [WIDTH-1:0]    alu_b,
    output logic [2:0]          alu_op,
    input  logic [WIDTH-1:0]    alu_result,
    input  logic                alu_zero,
    input  logic                alu_carry,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [WIDTH-1:0]    rsp_result,
    output logic                rsp_zero,
    output logic                rsp_carry,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] id_reg;
    logic [IDW-1:0] grant_idx;
    logic           grant_found;
    logic           offer;
    logic           transfer;

    // Round-robin search starting just after the last granted index, wrapping.
    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(idx);
            end
        end
    end

    // A grant is only offered when the response slot is free or draining this cycle,
    // so back-to-back ops overlap the RESP of one with the acceptance of the next.
    assign offer    = !rst && ((state == IDLE) || ((state == RESP) && rsp_ready));
    assign transfer = offer && grant_found;

    always_comb begin
        req_ready = '0;
        if (transfer) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= IDW'(NREQ - 1);
            id_reg     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_carry  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (transfer) begin
                        alu_a  <= req_a[int'(grant_idx)*WIDTH +: WIDTH];
                        alu_b  <= req_b[int'(grant_idx)*WIDTH +: WIDTH];
                        alu_op <= req_op[int'(grant_idx)*3 +: 3];
                        id_reg <= grant_idx;
                        ptr    <= grant_idx;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    // ALU has had a full cycle to settle on the registered operands.
                    rsp_result <= alu_result;
                    rsp_zero   <= alu_zero;
                    rsp_carry  <= alu_carry;
                    rsp_id     <= id_reg;
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (transfer) begin
                            alu_a  <= req_a[int'(grant_idx)*WIDTH +: WIDTH];
                            alu_b  <= req_b[int'(grant_idx)*WIDTH +: WIDTH];
                            alu_op <= req_op[int'(grant_idx)*3 +: 3];
                            id_reg <= grant_idx;
                            ptr    <= grant_idx;
                            state  <= EXEC;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a behavioural ALU and response scoreboard

module tb_alu_arbiter;

    localparam int WIDTH = 4;
    localparam int NREQ  = 4;
    localparam int IDW   = 3;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ*3-1:0]     req_op;
    logic [WIDTH-1:0]      alu_a;
    logic [WIDTH-1:0]      alu_b;
    logic [2:0]            alu_op;
    logic [WIDTH-1:0]      alu_result;
    logic                  alu_zero;
    logic                  alu_carry;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_result;
    logic                  rsp_zero;
    logic                  rsp_carry;
    logic                  busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int rsp_count = 0;

    typedef struct packed {
        logic [IDW-1:0]   id;
        logic [WIDTH-1:0] r;
        logic             z;
        logic             c;
    } rsp_t;

    rsp_t sb_q[$];
    int   grant_q[$];
    int   gcyc_q[$];

    typedef struct {
        int               id;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [2:0]       op;
        logic [WIDTH-1:0] r;
        logic             z;
        logic             c;
    } vec_t;

    vec_t vecs[8];

    alu_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_carry(rsp_carry),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU: carry is carry-out for ADD, borrow for SUB, 0 otherwise.
    function automatic rsp_t ref_alu(input logic [IDW-1:0] id, input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b, input logic [2:0] op);
        rsp_t o;
        logic [WIDTH:0] s;
        o.id = id;
        o.c  = 1'b0;
        case (op)
            OP_ADD: begin s = {1'b0, a} + {1'b0, b}; o.r = s[WIDTH-1:0]; o.c = s[WIDTH]; end
            OP_SUB: begin o.r = a - b; o.c = (a < b); end
            OP_AND: o.r = a & b;
            OP_OR:  o.r = a | b;
            OP_XOR: o.r = a ^ b;
            default: o.r = a;
        endcase
        o.z = (o.r == '0);
        return o;
    endfunction

    always_comb begin
        rsp_t t;
        t          = ref_alu('0, alu_a, alu_b, alu_op);
        alu_result = t.r;
        alu_zero   = t.z;
        alu_carry  = t.c;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: push expected response on each accepted op, pop on each response handshake.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
        end else begin
            chk("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb_q.push_back(ref_alu(IDW'(i), req_a[i*WIDTH +: WIDTH],
                                           req_b[i*WIDTH +: WIDTH], req_op[i*3 +: 3]));
                    grant_q.push_back(i);
                    gcyc_q.push_back(cyc);
                end
            end
            if (rsp_valid && rsp_ready) begin
                rsp_count++;
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    rsp_t e;
                    e = sb_q.pop_front();
                    chk("sb_id", 32'(rsp_id), 32'(e.id));
                    chk("sb_result", 32'(rsp_result), 32'(e.r));
                    chk("sb_zero", 32'(rsp_zero), 32'(e.z));
                    chk("sb_carry", 32'(rsp_carry), 32'(e.c));
                end
            end
        end
    end

    task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [2:0] op);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
        req_op[i*3 +: 3]        = op;
    endtask

    task automatic wait_grant(input int i);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (req_ready[i]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("grant_wait", 32'(ok), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        logic [WIDTH-1:0] s_r;
        logic [IDW-1:0]   s_id;
        logic             s_z, s_c;
        int               exp_order[6];

        vecs[0] = '{0, 4'd9,  4'd8,  OP_ADD, 4'd1,  1'b0, 1'b1};
        vecs[1] = '{1, 4'd3,  4'd3,  OP_SUB, 4'd0,  1'b1, 1'b0};
        vecs[2] = '{2, 4'd5,  4'd7,  OP_SUB, 4'd14, 1'b0, 1'b1};
        vecs[3] = '{3, 4'd12, 4'd10, OP_AND, 4'd8,  1'b0, 1'b0};
        vecs[4] = '{0, 4'd5,  4'd10, OP_OR,  4'd15, 1'b0, 1'b0};
        vecs[5] = '{1, 4'd6,  4'd6,  OP_XOR, 4'd0,  1'b1, 1'b0};
        vecs[6] = '{2, 4'd7,  4'd8,  OP_ADD, 4'd15, 1'b0, 1'b0};
        vecs[7] = '{3, 4'd15, 4'd1,  OP_ADD, 4'd0,  1'b1, 1'b1};
        exp_order = '{0, 1, 2, 3, 0, 1};

        // Reset with every requester asserting: no grant may leak out.
        rst = 1'b1; req_valid = 4'hF; rsp_ready = 1'b1;
        req_a = '0; req_b = '0; req_op = '0;
        @(negedge clk);
        chk("rst_ready_zero", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_result", 32'(rsp_result), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; req_valid = '0;
        @(negedge clk);
        chk("idle_no_req_ready", 32'(req_ready), 32'd0);
        chk("idle_no_req_busy", 32'(busy), 32'd0);

        // Single-requester vectors: latency T+2, busy for exactly 2 cycles.
        for (int v = 0; v < 8; v++) begin
            @(posedge clk); #1;
            set_req(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].op);
            req_valid = NREQ'(1 << vecs[v].id);
            wait_grant(vecs[v].id);
            @(posedge clk); #1;
            req_valid = '0;
            @(negedge clk);
            chk("vec_exec_busy", 32'(busy), 32'd1);
            chk("vec_exec_rsp_valid", 32'(rsp_valid), 32'd0);
            @(negedge clk);
            chk("vec_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("vec_rsp_id", 32'(rsp_id), 32'(vecs[v].id));
            chk("vec_result", 32'(rsp_result), 32'(vecs[v].r));
            chk("vec_zero", 32'(rsp_zero), 32'(vecs[v].z));
            chk("vec_carry", 32'(rsp_carry), 32'(vecs[v].c));
            chk("vec_resp_busy", 32'(busy), 32'd1);
            @(negedge clk);
            chk("vec_after_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("vec_after_busy", 32'(busy), 32'd0);
        end

        // All four requesters continuously valid: round-robin order, one grant per 2 cycles.
        grant_q.delete(); gcyc_q.delete();
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++) set_req(i, WIDTH'(i + 1), WIDTH'(2 * i), 3'(i));
        req_valid = 4'hF;
        repeat (11) @(negedge clk);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (3) @(negedge clk);
        chk("rr_grant_count", 32'(grant_q.size()), 32'd6);
        if (grant_q.size() >= 6) begin
            for (int k = 0; k < 6; k++) begin
                chk("rr_grant_order", 32'(grant_q[k]), 32'(exp_order[k]));
                if (k > 0) chk("rr_grant_spacing", 32'(gcyc_q[k] - gcyc_q[k-1]), 32'd2);
            end
        end

        // Stalled response: req2 granted, req1 raised during EXEC, rsp_ready low for 5 cycles.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        set_req(2, 4'd2, 4'd1, OP_ADD);
        req_valid = 4'b0100;
        wait_grant(2);
        @(posedge clk); #1;
        set_req(1, 4'd4, 4'd1, OP_SUB);
        req_valid = 4'b0010;
        @(negedge clk);
        chk("exec_no_grant", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
        s_r = rsp_result; s_id = rsp_id; s_z = rsp_zero; s_c = rsp_carry;
        chk("stall_rsp_id", 32'(rsp_id), 32'd2);
        chk("stall_result", 32'(rsp_result), 32'd3);
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk("stall_valid_held", 32'(rsp_valid), 32'd1);
            chk("stall_stable", 32'({rsp_id, rsp_result, rsp_zero, rsp_carry}),
                32'({s_id, s_r, s_z, s_c}));
            chk("stall_no_grant", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("release_grant_req1", 32'(req_ready), 32'b0010);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        chk("req1_rsp_id", 32'(rsp_id), 32'd1);
        chk("req1_result", 32'(rsp_result), 32'd3);
        @(negedge clk);

        // Wrap priority: last grant was 1, so 2 beats 0; then 0 follows back-to-back.
        @(posedge clk); #1;
        set_req(0, 4'd1, 4'd1, OP_AND);
        set_req(2, 4'd8, 4'd8, OP_ADD);
        req_valid = 4'b0101;
        @(negedge clk);
        chk("wrap_grant_req2", 32'(req_ready), 32'b0100);
        @(posedge clk); #1;
        req_valid = 4'b0001;
        @(negedge clk);
        @(negedge clk);
        chk("wrap_resp_id", 32'(rsp_id), 32'd2);
        chk("wrap_backtoback_req0", 32'(req_ready), 32'b0001);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (3) @(negedge clk);

        // Reset during EXEC of req3: response discarded, pointer back to NREQ-1.
        @(posedge clk); #1;
        set_req(3, 4'd7, 4'd1, OP_ADD);
        req_valid = 4'b1000;
        @(negedge clk);
        chk("mid_rst_grant_req3", 32'(req_ready), 32'b1000);
        @(posedge clk); #1;
        req_valid = '0;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_exec_busy", 32'(busy), 32'd1);
        chk("mid_rst_ready_zero", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        set_req(0, 4'd1, 4'd2, OP_OR);
        req_valid = 4'b1001;
        @(negedge clk);
        chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_grant_req0", 32'(req_ready), 32'b0001);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        chk("post_rst_exec_no_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("post_rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("post_rst_result", 32'(rsp_result), 32'd3);
        repeat (3) @(negedge clk);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        chk("rsp_total", 32'(rsp_count), 32'd19);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
